melody_sequencer: RTL and testbench

- Programmable successor to the fixed-score tone player. It holds a score RAM of DEPTH (pitch, duration) entries that is written at run time, and plays entries 0..last_idx in order.
- Duration is counted in sample ticks from an internal programmable tick divider.
- Supports one-shot or loop mode, rests, and stop.
- Outputs drive the existing sine clkgen maxval (pitch_o) and the sine/DAC per-note reset (note_start).

---
 rtl/melody_sequencer.sv | 141 ++++++++++++++
 tb/tb_melody_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : melody_sequencer
// Brief    : Plays a run-time programmable (pitch, duration) score RAM in order,
//            with one-shot/loop modes, rests, stop and a programmable tick.
// Revision : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
    parameter int PITCH_W = 9,
    parameter int DUR_W   = 13,
    parameter int ADDR_W  = 5,
    parameter int TICK_W  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TICK_W-1:0]  tick_maxval,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic [ADDR_W-1:0]  last_idx,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [PITCH_W-1:0] pitch_o,
    output logic               note_valid,
    output logic               note_start,
    output logic               busy,
    output logic               done
);

    localparam int c_DEPTH  = 1 << ADDR_W;
    localparam int c_WORD_W = PITCH_W + DUR_W;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_LOAD  = 2'd2;
    localparam logic [1:0] c_S_PLAY  = 2'd3;

    logic [c_WORD_W-1:0] r_mem [0:c_DEPTH-1];
    logic [c_WORD_W-1:0] r_rd_data;
    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [DUR_W-1:0]    r_dur;
    logic [DUR_W-1:0]    r_dur_ctr;
    logic [TICK_W-1:0]   r_tick_ctr;

    logic [PITCH_W-1:0]  w_rd_pitch;
    logic [DUR_W-1:0]    w_rd_dur;
    logic [DUR_W-1:0]    w_dur_eff;
    logic                w_tick;
    logic                w_last_tick;

    assign w_rd_pitch  = r_rd_data[c_WORD_W-1:DUR_W];
    assign w_rd_dur    = r_rd_data[DUR_W-1:0];
    assign w_dur_eff   = (r_dur == '0) ? DUR_W'(1) : r_dur;
    assign w_tick      = (r_tick_ctr == tick_maxval);
    assign w_last_tick = (r_dur_ctr == (w_dur_eff - 1'b1));
    assign busy        = (r_state != c_S_IDLE);

    // Score RAM: read-before-write, so a same-address collision returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_pitch, wr_dur};
        end
        r_rd_data <= r_mem[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_idx      <= '0;
            r_dur      <= '0;
            r_dur_ctr  <= '0;
            r_tick_ctr <= '0;
            pitch_o    <= '0;
            note_valid <= 1'b0;
            note_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            note_start <= 1'b0;
            done       <= 1'b0;
            if (stop && (r_state != c_S_IDLE)) begin
                r_state    <= c_S_IDLE;
                r_idx      <= '0;
                r_dur_ctr  <= '0;
                r_tick_ctr <= '0;
                pitch_o    <= '0;
                note_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (start && !stop) begin
                            r_state <= c_S_FETCH;
                            r_idx   <= '0;
                        end
                    end
                    c_S_FETCH: begin
                        r_state <= c_S_LOAD;
                    end
                    c_S_LOAD: begin
                        r_dur      <= w_rd_dur;
                        r_dur_ctr  <= '0;
                        r_tick_ctr <= '0;
                        pitch_o    <= w_rd_pitch;
                        note_valid <= (w_rd_pitch != '0);
                        note_start <= 1'b1;
                        r_state    <= c_S_PLAY;
                    end
                    default: begin
                        if (w_tick) begin
                            r_tick_ctr <= '0;
                            if (w_last_tick) begin
                                r_dur_ctr <= '0;
                                // pitch_o/note_valid are left untouched so the DAC holds through the gap
                                if (r_idx != last_idx) begin
                                    r_idx   <= r_idx + 1'b1;
                                    r_state <= c_S_FETCH;
                                end else if (loop_en) begin
                                    r_idx   <= '0;
                                    r_state <= c_S_FETCH;
                                end else begin
                                    r_state    <= c_S_IDLE;
                                    done       <= 1'b1;
                                    pitch_o    <= '0;
                                    note_valid <= 1'b0;
                                end
                            end else begin
                                r_dur_ctr <= r_dur_ctr + 1'b1;
                            end
                        end else begin
                            r_tick_ctr <= r_tick_ctr + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_melody_sequencer
// Brief    : Randomized + directed scoreboard bench for melody_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

    localparam int c_DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] tick_maxval;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [8:0]  wr_pitch;
    logic [12:0] wr_dur;
    logic [4:0]  last_idx;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic [8:0]  pitch_o;
    logic        note_valid;
    logic        note_start;
    logic        busy;
    logic        done;

    melody_sequencer dut (
        .clk(clk), .reset(reset), .tick_maxval(tick_maxval),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_dur(wr_dur),
        .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop),
        .pitch_o(pitch_o), .note_valid(note_valid), .note_start(note_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int cyc;
        int pitch;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  cur_pitch = 0;
    int  sc_p [c_DEPTH];
    int  sc_d [c_DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops one expected event per note_start/done, otherwise checks held outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (note_start || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_kind", int'(done), int'(e.is_done));
                    chk("event_cycle", cyc, e.cyc);
                    if (e.is_done) begin
                        chk("done_busy", int'(busy), 0);
                        chk("done_pitch", int'(pitch_o), 0);
                        cur_pitch = 0;
                    end else begin
                        chk("note_pitch", int'(pitch_o), e.pitch);
                        chk("note_valid", int'(note_valid), int'(e.pitch != 0));
                        chk("note_busy", int'(busy), 1);
                        cur_pitch = e.pitch;
                    end
                end
            end else if (busy) begin
                chk("hold_pitch", int'(pitch_o), cur_pitch);
                chk("hold_valid", int'(note_valid), int'(cur_pitch != 0));
            end else begin
                cur_pitch = 0;
                chk("idle_pitch", int'(pitch_o), 0);
                chk("idle_valid", int'(note_valid), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int p, input int d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_pitch = 9'(p); wr_dur = 13'(d);
        sc_p[a] = p; sc_d[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        step();
        chk("end_busy", int'(busy), 0);
    endtask

    // Reference model: walks the score by the playback rules and queues every event.
    task automatic run_seq(input bit lp, input int abort_at, input bit use_reset, input bit live);
        int n, s, t, idx, len;
        n = cyc + 1;
        s = (abort_at > 0) ? n + abort_at : 32'h3fff_ffff;
        t = n + 2;
        idx = 0;
        forever begin
            if (t > s) break;
            q.push_back('{1'b0, t, sc_p[idx]});
            len = ((sc_d[idx] == 0) ? 1 : sc_d[idx]) * (int'(tick_maxval) + 1);
            if (idx == int'(last_idx)) begin
                if (!lp) begin
                    if (t + len <= s) q.push_back('{1'b1, t + len, 0});
                    break;
                end
                idx = 0;
            end else begin
                idx = (idx + 1) % c_DEPTH;
            end
            t += len + 2;
        end
        loop_en = lp;
        start = 1'b1;
        step();
        start = 1'b0;
        if (live) begin
            repeat (4) step();
            wr_en = 1'b1; wr_addr = 5'd1; wr_pitch = 9'(sc_p[1]); wr_dur = 13'(sc_d[1]);
            start = 1'b1;
            step();
            wr_en = 1'b0; start = 1'b0;
        end
        if (abort_at > 0) begin
            while (cyc < s) step();
            if (use_reset) reset = 1'b1; else stop = 1'b1;
            step();
            reset = 1'b0; stop = 1'b0;
            @(negedge clk);
            chk("abort_busy", int'(busy), 0);
            chk("abort_pitch", int'(pitch_o), 0);
            chk("abort_valid", int'(note_valid), 0);
            chk("abort_done", int'(done), 0);
            step();
        end
        drain();
    endtask

    initial begin
        reset = 1'b1; tick_maxval = '0; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0;
        wr_dur = '0; last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin sc_p[i] = 0; sc_d[i] = 0; end
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_note_start", int'(note_start), 0);
        chk("reset_done", int'(done), 0);
        step();

        // One-shot, then loop with stop, then stop mid-note of entry 1
        write_entry(0, 177, 2);
        write_entry(1, 199, 1);
        write_entry(2, 133, 3);
        last_idx = 5'd2; tick_maxval = 11'd3;
        run_seq(1'b0, 0, 1'b0, 1'b0);
        run_seq(1'b1, 70, 1'b0, 1'b0);
        run_seq(1'b0, 14, 1'b0, 1'b0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        repeat (3) step();
        chk("start_stop_idle", int'(busy), 0);

        // Reset mid-play, then restart from retained RAM
        run_seq(1'b0, 6, 1'b1, 1'b0);
        run_seq(1'b0, 0, 1'b0, 1'b0);

        // Rest and zero duration
        write_entry(0, 0, 2);
        write_entry(1, 211, 0);
        last_idx = 5'd1; tick_maxval = 11'd0;
        run_seq(1'b0, 0, 1'b0, 1'b0);

        // Live write of entry 1 and ignored start while busy
        write_entry(0, 150, 3);
        write_entry(1, 10, 2);
        tick_maxval = 11'd3;
        sc_p[1] = 237; sc_d[1] = 1;
        run_seq(1'b0, 0, 1'b0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            int last;
            last = $urandom_range(0, 4);
            for (int i = 0; i <= last; i++)
                write_entry(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 511),
                            $urandom_range(0, 3));
            last_idx = 5'(last);
            tick_maxval = 11'($urandom_range(0, 3));
            if (r % 3 == 2) run_seq(1'b1, $urandom_range(5, 60), 1'(r % 2), 1'b0);
            else            run_seq(1'b0, 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
